// File: rtl/key_expand.sv
// AES-128 key expansion with a valid/ready round-key stream.
// A key accepted in IDLE is emitted as round 0, then rounds 1..10 follow one
// per accepted transfer. Optional round-key store, enabled by defining
// KEY_EXPAND_STORE_EN, adds a registered random-access read port.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a key; key_ready=1, rk_valid=0
// RUN   | round_key/round_idx presented; advances on each rk_ready

// AES S-box computed as GF(2^8) inverse (x^254) followed by the affine map.
module key_expand_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // x^254 = product of x^(2^k) for k=1..7; maps 0 to 0 as AES requires.
  always_comb begin
    logic [7:0] p;
    logic [7:0] r;
    p = in_byte;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    out_byte = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
               ^ {r[3:0], r[7:4]} ^ 8'h63;
  end

endmodule

module key_expand (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         rk_last
`ifdef KEY_EXPAND_STORE_EN
  ,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key
`endif
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t       state;
  state_t       state_next;
  logic         accept;
  logic         advance;
  logic [7:0]   rcon;
  logic [31:0]  rot_word;
  logic [31:0]  sub_word;
  logic [31:0]  t_word;
  logic [127:0] next_key;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    key_ready  = 1'b0;
    rk_valid   = 1'b0;
    case (state)
      IDLE: begin
        key_ready = 1'b1;
        if (key_valid) state_next = RUN;
      end
      RUN: begin
        rk_valid = 1'b1;
        if (rk_ready && (round_idx == 4'd10)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept  = (state == IDLE) && key_valid;
  assign advance = (state == RUN) && rk_ready && (round_idx != 4'd10);
  assign rk_last = rk_valid && (round_idx == 4'd10);

  // Rcon for the round being produced (current index + 1).
  always_comb begin
    case (round_idx)
      4'd0:    rcon = 8'h01;
      4'd1:    rcon = 8'h02;
      4'd2:    rcon = 8'h04;
      4'd3:    rcon = 8'h08;
      4'd4:    rcon = 8'h10;
      4'd5:    rcon = 8'h20;
      4'd6:    rcon = 8'h40;
      4'd7:    rcon = 8'h80;
      4'd8:    rcon = 8'h1b;
      4'd9:    rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign rot_word = {round_key[23:0], round_key[31:24]};

  key_expand_sbox u_sbox3 (.in_byte(rot_word[31:24]), .out_byte(sub_word[31:24]));
  key_expand_sbox u_sbox2 (.in_byte(rot_word[23:16]), .out_byte(sub_word[23:16]));
  key_expand_sbox u_sbox1 (.in_byte(rot_word[15:8]),  .out_byte(sub_word[15:8]));
  key_expand_sbox u_sbox0 (.in_byte(rot_word[7:0]),   .out_byte(sub_word[7:0]));

  // Chained word XORs: each new word depends on the previous new word.
  always_comb begin
    t_word = sub_word ^ {rcon, 24'h0};
    next_key[127:96] = round_key[127:96] ^ t_word;
    next_key[95:64]  = round_key[95:64]  ^ next_key[127:96];
    next_key[63:32]  = round_key[63:32]  ^ next_key[95:64];
    next_key[31:0]   = round_key[31:0]   ^ next_key[63:32];
  end

  // Round key and index; held while stalled because advance needs rk_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      round_key <= 128'h0;
      round_idx <= 4'd0;
    end else if (accept) begin
      round_key <= key_in;
      round_idx <= 4'd0;
    end else if (advance) begin
      round_key <= next_key;
      round_idx <= round_idx + 4'd1;
    end
  end

`ifdef KEY_EXPAND_STORE_EN
  logic [127:0] store [11];

  // Capture each round key while it is presented; rewriting the same value
  // during a stall is harmless.
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      for (int i = 0; i < 11; i++) store[i] <= 128'h0;
    end else if ((state == RUN) && (round_idx <= 4'd10)) begin
      store[round_idx] <= round_key;
    end
  end

  // Registered read port; out-of-range indices read as zero.
  always_ff @(posedge clk) begin
    if (rst)                  rd_key <= 128'h0;
    else if (rd_idx <= 4'd10) rd_key <= store[rd_idx];
    else                      rd_key <= 128'h0;
  end
`endif

endmodule

// File: tb/tb_key_expand.sv
// Bench for key_expand: FIPS-197 style expansion model, per-cycle compare of
// the round-key stream, and directed latency/reset/back-pressure scenarios.
// Store read port scenarios are built when KEY_EXPAND_STORE_EN is defined.
module tb_key_expand;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ZERO_KEY = 128'h0;

  localparam logic [127:0] SBOX_ROWS [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic         clk;
  logic         rst;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         rk_valid;
  logic         rk_ready;
  logic         rk_last;
`ifdef KEY_EXPAND_STORE_EN
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  key_expand dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid),
    .key_ready(key_ready), .round_key(round_key), .round_idx(round_idx),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_last(rk_last)
`ifdef KEY_EXPAND_STORE_EN
    , .rd_idx(rd_idx), .rd_key(rd_key)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [127:0] row;
    row = SBOX_ROWS[x[7:4]];
    return row[127 - 8*x[3:0] -: 8];
  endfunction

  function automatic logic [31:0] sub_word_ref(input logic [31:0] w);
    return {sbox_ref(w[31:24]), sbox_ref(w[23:16]), sbox_ref(w[15:8]), sbox_ref(w[7:0])};
  endfunction

  // Whole schedule as 11 packed round keys, round i at bits [i*128 +: 128].
  function automatic logic [1407:0] expand(input logic [127:0] k);
    logic [31:0]   w [44];
    logic [31:0]   temp;
    logic [7:0]    rc;
    logic [1407:0] sched;
    w[0] = k[127:96]; w[1] = k[95:64]; w[2] = k[63:32]; w[3] = k[31:0];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      temp = w[i-1];
      if (i % 4 == 0) begin
        temp = sub_word_ref({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ temp;
    end
    for (int r = 0; r < 11; r++)
      sched[r*128 +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return sched;
  endfunction

  function automatic logic [127:0] rk_of(input logic [1407:0] s, input int i);
    return s[i*128 +: 128];
  endfunction

  logic          m_busy;
  logic          m_clean;
  int            m_idx;
  logic [1407:0] m_sched;
  logic          chk_on;

  // Model of the transfer protocol, advanced on the same edges as the DUT.
  always @(posedge clk) begin
    if (rst) begin
      m_busy  <= 1'b0;
      m_clean <= 1'b1;
      m_idx   <= 0;
    end else if (!m_busy) begin
      if (key_valid) begin
        m_busy  <= 1'b1;
        m_clean <= 1'b0;
        m_idx   <= 0;
        m_sched <= expand(key_in);
      end
    end else if (rk_ready) begin
      if (m_idx == 10) m_busy <= 1'b0;
      else             m_idx <= m_idx + 1;
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("rk_valid", 128'(rk_valid), 128'(m_busy));
      check("key_ready", 128'(key_ready), 128'(!m_busy));
      check("rk_last", 128'(rk_last), 128'(m_busy && (m_idx == 10)));
      if (m_busy) begin
        check("round_key", round_key, rk_of(m_sched, m_idx));
        check("round_idx", 128'(round_idx), 128'(m_idx));
      end else if (m_clean) begin
        check("reset_round_key", round_key, 128'h0);
        check("reset_round_idx", 128'(round_idx), 128'h0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_key(input logic [127:0] k);
    key_valid = 1'b1;
    key_in    = k;
    step();
    key_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (m_busy && n < budget) begin
      step();
      n++;
    end
    check(name, 128'(m_busy), 128'h0);
  endtask

  initial begin
    logic [1407:0] s;
    int cnt;
    int xfers;

    chk_on    = 1'b0;
    rst       = 1'b1;
    key_in    = 128'h0;
    key_valid = 1'b0;
    rk_ready  = 1'b0;
`ifdef KEY_EXPAND_STORE_EN
    rd_idx    = 4'd0;
`endif

    // Pin the model to published vectors.
    s = expand(FIPS_KEY);
    check("pin_fips_r0", rk_of(s, 0), FIPS_KEY);
    check("pin_fips_r1", rk_of(s, 1), 128'ha0fafe1788542cb123a339392a6c7605);
    check("pin_fips_r10", rk_of(s, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    s = expand(ZERO_KEY);
    check("pin_zero_r1", rk_of(s, 1), 128'h62636363626363636263636362636363);
    check("pin_zero_r10", rk_of(s, 10), 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    repeat (3) @(posedge clk);
    #1;
    rst    = 1'b0;
    chk_on = 1'b1;
    @(negedge clk);
    check("rst_key_ready", 128'(key_ready), 128'h1);
    check("rst_rk_valid", 128'(rk_valid), 128'h0);
    check("rst_rk_last", 128'(rk_last), 128'h0);
    check("rst_round_idx", 128'(round_idx), 128'h0);
    check("rst_round_key", round_key, 128'h0);
    step();

    // FIPS key, no back-pressure: idx i presented at T+1+i.
    rk_ready = 1'b1;
    send_key(FIPS_KEY);
    check("fips_idx0", round_key, FIPS_KEY);
    cnt = 0;
    while (!(rk_valid && rk_last) && cnt < 40) begin
      step();
      cnt++;
      if (cnt == 1) check("fips_idx1", round_key, 128'ha0fafe1788542cb123a339392a6c7605);
    end
    check("fips_last_latency", 128'(cnt), 128'd10);
    check("fips_idx10", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("fips_last_flag", 128'(rk_last), 128'h1);
    step();
    check("fips_t12_key_ready", 128'(key_ready), 128'h1);
    check("fips_t12_rk_valid", 128'(rk_valid), 128'h0);

    // All-zero key.
    send_key(ZERO_KEY);
    wait_idle("zero_done", 40);

    // Random back-pressure with the FIPS key: exactly 11 transfers.
    rk_ready = 1'b0;
    send_key(FIPS_KEY);
    xfers = 0;
    cnt = 0;
    while (m_busy && cnt < 400) begin
      rk_ready = 1'($urandom_range(0, 1));
      if (rk_valid && rk_ready) xfers++;
      step();
      cnt++;
    end
    check("stall_done", 128'(m_busy), 128'h0);
    check("stall_xfers", 128'(xfers), 128'd11);

    // Reset while round 5 is presented.
    rk_ready = 1'b1;
    send_key(FIPS_KEY);
    cnt = 0;
    while (m_idx != 5 && cnt < 20) begin
      step();
      cnt++;
    end
    check("mid_reached_idx5", 128'(round_idx), 128'd5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_rk_valid", 128'(rk_valid), 128'h0);
    check("mid_rst_key_ready", 128'(key_ready), 128'h1);
    send_key(ZERO_KEY);
    wait_idle("mid_zero_done", 40);

    // key_valid held through RUN with a different key_in.
    key_valid = 1'b1;
    key_in    = FIPS_KEY;
    step();
    key_in    = ZERO_KEY;
    cnt = 0;
    while (!(m_busy && m_idx == 10) && cnt < 40) begin
      step();
      cnt++;
    end
    check("hold_first_idx10", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    step();
    check("hold_idle_key_ready", 128'(key_ready), 128'h1);
    step();
    key_valid = 1'b0;
    check("hold_second_valid", 128'(rk_valid), 128'h1);
    check("hold_second_idx0", round_key, ZERO_KEY);
    wait_idle("hold_second_done", 40);

`ifdef KEY_EXPAND_STORE_EN
    send_key(FIPS_KEY);
    wait_idle("store_fill_done", 40);
    rd_idx = 4'd10;
    @(posedge clk);
    @(negedge clk);
    check("store_rd10", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    #1;
    rd_idx = 4'd15;
    @(posedge clk);
    @(negedge clk);
    check("store_rd15", rd_key, 128'h0);
    #1;
    rd_idx = 4'd1;
    @(posedge clk);
    @(negedge clk);
    check("store_rd1", rd_key, 128'ha0fafe1788542cb123a339392a6c7605);
`endif

    step();
    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
